// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile
//   APB completer that fronts a word-addressed register file. Every access
//   inserts WAIT_CYCLES wait states. Misaligned, out-of-range and read-only
//   accesses complete with an error response.
//
//   Each register sits at paddr = 4*i. The word at 0x3C is not storage and
//   always reads back ID_VALUE.
//
// Ports
//   pclk      in   1   APB clock
//   preset_n  in   1   asynchronous active-low reset
//   psel      in   1   slave select
//   penable   in   1   access-phase indicator
//   pwrite    in   1   1 = write, 0 = read
//   paddr     in   8   byte address
//   pwdata    in  32   write data
//   prdata    out 32   read data (zero unless pready and no error)
//   pready    out  1   transfer complete (registered)
//   pslverr   out  1   error response, qualified by pready (registered)
module apb_slave_regfile #(
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001,
  parameter int          NUM_REGS    = 16
) (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] ACCESS_WAIT = 2'd1;
  localparam logic [1:0] ACCESS_DONE = 2'd2;

  localparam int          IDX_W      = $clog2(NUM_REGS);
  localparam logic [7:0]  ID_ADDR    = 8'h3C;
  localparam logic [8:0]  ADDR_LIMIT = 9'(4 * NUM_REGS);
  localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [3:0]       wait_cnt;
  logic [7:0]       addr_q;
  logic             write_q;
  logic [31:0]      wdata_q;
  logic [31:0]      regs [NUM_REGS];

  logic             active;
  logic             setup;
  logic [7:0]       dec_addr;
  logic             dec_write;
  logic [IDX_W-1:0] dec_idx;
  logic             dec_err;
  logic [31:0]      rd_value;
  logic             commit;

  assign active = psel & penable;
  assign setup  = psel & ~penable;

  // The response is registered. It is therefore computed in the cycle
  // before ACCESS_DONE. With zero wait states, that cycle is the setup
  // cycle itself, so decode the live bus while IDLE. In every other state,
  // decode the latched copy, so mid-access bus changes are ignored.
  assign dec_addr  = (state == IDLE) ? paddr  : addr_q;
  assign dec_write = (state == IDLE) ? pwrite : write_q;
  assign dec_idx   = dec_addr[IDX_W+1:2];

  assign dec_err = (dec_addr[1:0] != 2'b00) ||
                   ({1'b0, dec_addr} >= ADDR_LIMIT) ||
                   (dec_write && (dec_addr == ID_ADDR));

  assign rd_value = (dec_addr == ID_ADDR) ? ID_VALUE : regs[dec_idx];

  // A write commits only if the master holds the access phase through the
  // ACCESS_DONE cycle. This means an abort in that cycle still blocks the write.
  assign commit = (state == ACCESS_DONE) && active && write_q && !dec_err;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (setup) state_nxt = (WAIT_LOAD == 4'd0) ? ACCESS_DONE : ACCESS_WAIT;
      end
      ACCESS_WAIT: begin
        if (!active)               state_nxt = IDLE;
        else if (wait_cnt <= 4'd1) state_nxt = ACCESS_DONE;
      end
      ACCESS_DONE: state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= 8'h00;
      write_q  <= 1'b0;
      wdata_q  <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && setup) begin
        addr_q   <= paddr;
        write_q  <= pwrite;
        wdata_q  <= pwdata;
        wait_cnt <= WAIT_LOAD;
      end else if (state == ACCESS_WAIT && active) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // The outputs are registered so that they are valid exactly while the
  // FSM sits in ACCESS_DONE.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= 32'h0;
    end else begin
      pready  <= (state_nxt == ACCESS_DONE);
      pslverr <= (state_nxt == ACCESS_DONE) && dec_err;
      prdata  <= ((state_nxt == ACCESS_DONE) && !dec_err) ? rd_value : 32'h0;
    end
  end

  // The slot behind the ID address is never written, because the error
  // decode rejects writes to it.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h0;
    end else if (commit) begin
      regs[addr_q[IDX_W+1:2]] <= wdata_q;
    end
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB completer (slave) on the 8-bit address / 32-bit data APB bus used by the team's master agent.
- Holds a 16-entry word-addressed register file with a read-only ID register.
- Inserts a programmable number of wait states and flags error responses.
- Sits behind the APB interface as the DUT responding to the master driver. Its outputs must satisfy the team's APB protocol checks (stable select/address/data, penable handshake).

Parameters:
- WAIT_CYCLES, 0, number of access-phase cycles with pready low before pready is asserted (range 0..15).
- ID_VALUE, 32'hA5B0_0001, constant returned when reading the ID register at 0x3C.
- NUM_REGS, 16, number of 32-bit registers, mapped at paddr = 4*i.

Ports:
- pclk  input  1  APB clock; all state updates on the rising edge.
- preset_n  input  1  asynchronous active-low reset.
- psel  input  1  slave select from master.
- penable  input  1  access-phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  8  byte address.
- pwdata  input  32  write data.
- prdata  output  32  read data, valid only when pready=1.
- pready  output  1  transfer-complete indication (registered).
- pslverr  output  1  error response, valid only when pready=1 (registered).

Behaviour:
- Reset (preset_n low, asynchronous): FSM to IDLE; pready=0, pslverr=0, prdata=0; registers 0..14 cleared to 0. The register at 0x3C is not storage and always reads ID_VALUE.
- FSM states: IDLE, ACCESS_WAIT, ACCESS_DONE.
  - IDLE: on psel=1, penable=0 (setup phase), latch paddr, pwrite and pwdata, and load wait counter = WAIT_CYCLES. If WAIT_CYCLES==0, go to ACCESS_DONE; otherwise go to ACCESS_WAIT.
  - ACCESS_WAIT: pready=0. Counter decrements each cycle while psel=1 and penable=1. When counter reaches 1, next state is ACCESS_DONE.
  - ACCESS_DONE: pready=1 for exactly one cycle, then IDLE. Back-to-back transfers are allowed: a new setup phase in the following cycle is accepted from IDLE.
- Latency: the access phase lasts WAIT_CYCLES+1 cycles. pready is high in the last of these cycles.
- Error decode (pslverr=1 together with pready=1):
  - paddr[1:0] != 0 (misaligned);
  - paddr >= 4*NUM_REGS (0x40..0xFF);
  - write to 0x3C (read-only).
- Write commit: on the rising edge ending the ACCESS_DONE cycle, only if pwrite=1 and no error. On error, no register changes.
- Read data:
  - prdata = register[paddr>>2] (or ID_VALUE at 0x3C) during ACCESS_DONE.
  - prdata = 0 on error reads and in every cycle with pready=0.
- pready and pslverr are 0 in all states except ACCESS_DONE.
- Abort handling: if psel or penable drops during ACCESS_WAIT or ACCESS_DONE, return to IDLE next cycle. No write occurs and pready/pslverr are 0 from that cycle.
- Stray penable=1 in IDLE (without a preceding setup phase) is ignored.
- The latched address/data are used for decode and commit. Changes to paddr/pwdata mid-access (a master protocol violation) have no effect.
- Reset asserted mid-transfer: the transfer is aborted immediately and no write occurs.

Test Plan:
- WAIT_CYCLES=0: write 0xDEADBEEF to 0x08, then read 0x08 -> each access phase is 1 cycle with pready=1, pslverr=0, and the read returns prdata=0xDEADBEEF.
- WAIT_CYCLES=3: write 0x12345678 to 0x10 -> pready low for 3 access cycles, high in the 4th; a read of 0x10 with the same timing returns 0x12345678.
- Read 0x3C -> prdata=0xA5B00001, pslverr=0. Write 0xFFFFFFFF to 0x3C -> pslverr=1 with pready, and a following read still returns 0xA5B00001.
- Error addresses: read 0x40 -> pslverr=1, prdata=0. Write to 0x05 -> pslverr=1, and register 0x04 is unchanged.
- Back-to-back: writes to 0x00, 0x04, 0x08 with no idle cycles between them -> all three commit; reading them back returns the written values in order.
- Reset mid-access: WAIT_CYCLES=3, write 0xAAAA5555 to 0x0C, pulse preset_n low in the 2nd access cycle -> pready=0, then reading 0x0C returns 0x00000000.
